// File: rtl/ram_rd_chk_pkg.sv
// Shared definitions for the RAM read-side checker.
//   - chk_state_e : checker FSM encoding (CHK_SYNC, CHK_CHECK)
//   - ERR_CNT_W / SWEEP_CNT_W : widths of the error and sweep counters
//   - addr_to_data() : write pattern, the data word expected at an address
package ram_rd_chk_pkg;

  typedef enum logic [0:0] {
    CHK_SYNC  = 1'b0,
    CHK_CHECK = 1'b1
  } chk_state_e;

  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned SWEEP_CNT_W = 16;

  // The test pattern stores each address as its own data. Callers cast the
  // result to their data width (zero-extend or truncate).
  function automatic logic [31:0] addr_to_data(input logic [31:0] addr);
    return addr;
  endfunction

endpackage

// File: rtl/ram_rd_chk_align.sv
// rd_align_pipe: Lat-stage delay line for the {valid, addr} of a RAM read so
// that it lines up with the returned read data.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears the valid stages only
//   vld_i  : read issued this cycle
//   addr_i : address of the read issued
//   vld_o  : valid delayed by Lat cycles
//   addr_o : address delayed by Lat cycles
module rd_align_pipe #(
  parameter int unsigned Lat   = 1,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [AddrW-1:0] addr_i,
  output logic             vld_o,
  output logic [AddrW-1:0] addr_o
);

  logic [Lat-1:0]   vld_q;
  logic [AddrW-1:0] addr_q [Lat];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < int'(Lat); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Address stages carry no reset; they are qualified by the valids.
  always_ff @(posedge clk_i) begin
    addr_q[0] <= addr_i;
    for (int i = 1; i < int'(Lat); i++) begin
      addr_q[i] <= addr_q[i-1];
    end
  end

  assign vld_o  = vld_q[Lat-1];
  assign addr_o = addr_q[Lat-1];

endmodule

// File: rtl/ram_rd_chk.sv
// ram_rd_chk: read-side data checker for the dual-port RAM test path.
// Re-aligns read enable/address across the RAM read latency and checks every
// returned word against the pattern data == address, sweep by sweep.
//   clk            : checker clock (RAM read clock)
//   rst            : synchronous active-high reset
//   ram_rd_en      : read issued this cycle
//   ram_rd_addr    : address of the read issued
//   ram_rd_data    : RAM read data, valid RD_LAT cycles after the read
//   chk_done       : one-cycle pulse at the end of each sweep
//   chk_pass       : 1 if the last completed sweep had no error
//   err_flag       : sticky, set on the first error since reset
//   err_cnt        : erroneous samples since reset, saturating
//   first_err_addr : address of the first erroneous sample since reset
//   sweep_cnt      : completed sweeps, wrapping
module ram_rd_chk
  import ram_rd_chk_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ram_rd_en,
  input  logic [ADDR_W-1:0]      ram_rd_addr,
  input  logic [DATA_W-1:0]      ram_rd_data,
  output logic                   chk_done,
  output logic                   chk_pass,
  output logic                   err_flag,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [ADDR_W-1:0]      first_err_addr,
  output logic [SWEEP_CNT_W-1:0] sweep_cnt
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic              smp_vld;
  logic [ADDR_W-1:0] smp_addr;

  rd_align_pipe #(
    .Lat   (RD_LAT),
    .AddrW (ADDR_W)
  ) u_align (
    .clk_i  (clk),
    .rst_i  (rst),
    .vld_i  (ram_rd_en),
    .addr_i (ram_rd_addr),
    .vld_o  (smp_vld),
    .addr_o (smp_addr)
  );

  chk_state_e        state_q;
  logic [ADDR_W-1:0] exp_addr_q;
  logic              sweep_err_q;

  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              chk_now;
  logic              smp_err;
  logic              smp_last;

  always_comb begin
    // In SYNC the only sample accepted carries address 0, so it is checked
    // as the first sample of a sweep.
    exp_addr = (state_q == CHK_SYNC) ? '0 : exp_addr_q;
    exp_data = DATA_W'(addr_to_data(32'(smp_addr)));
    chk_now  = smp_vld && ((state_q == CHK_CHECK) || (smp_addr == '0));
    smp_err  = (ram_rd_data != exp_data) || (smp_addr != exp_addr);
    smp_last = (exp_addr == LastAddr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= CHK_SYNC;
      exp_addr_q     <= '0;
      sweep_err_q    <= 1'b0;
      chk_done       <= 1'b0;
      chk_pass       <= 1'b0;
      err_flag       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      sweep_cnt      <= '0;
    end else begin
      chk_done <= 1'b0;
      if (chk_now) begin
        // Once aligned, stay in CHECK: a later out-of-order address is an
        // error rather than a resync.
        state_q <= CHK_CHECK;
        if (smp_err) begin
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
          end
          if (!err_flag) begin
            err_flag       <= 1'b1;
            first_err_addr <= smp_addr;
          end
        end
        if (smp_last) begin
          chk_done    <= 1'b1;
          chk_pass    <= !(sweep_err_q || smp_err);
          sweep_cnt   <= sweep_cnt + SWEEP_CNT_W'(1);
          exp_addr_q  <= '0;
          sweep_err_q <= 1'b0;
        end else begin
          exp_addr_q  <= exp_addr + ADDR_W'(1);
          sweep_err_q <= sweep_err_q || smp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_rd_chk.sv
// Directed bench for ram_rd_chk. Two instances share one read stream: dut_a
// with a one-cycle RAM and dut_b with a three-cycle RAM. A small RAM model
// returns mem[] contents at each instance's latency.
module tb_ram_rd_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ram_rd_en;
  logic [4:0] ram_rd_addr;

  logic [7:0] mem [32];
  logic [7:0] rd_a, b1, b2, rd_b;

  always @(posedge clk) begin
    rd_a <= mem[ram_rd_addr];
    b1   <= mem[ram_rd_addr];
    b2   <= b1;
    rd_b <= b2;
  end

  logic        done_a, pass_a, flag_a, done_b, pass_b, flag_b;
  logic [7:0]  cnt_a, cnt_b;
  logic [4:0]  fea_a, fea_b;
  logic [15:0] sw_a, sw_b;

  ram_rd_chk #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(1)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .ram_rd_en      (ram_rd_en),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rd_data    (rd_a),
    .chk_done       (done_a),
    .chk_pass       (pass_a),
    .err_flag       (flag_a),
    .err_cnt        (cnt_a),
    .first_err_addr (fea_a),
    .sweep_cnt      (sw_a)
  );

  ram_rd_chk #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(3)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .ram_rd_en      (ram_rd_en),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rd_data    (rd_b),
    .chk_done       (done_b),
    .chk_pass       (pass_b),
    .err_flag       (flag_b),
    .err_cnt        (cnt_b),
    .first_err_addr (fea_b),
    .sweep_cnt      (sw_b)
  );

  // chk_done pulses seen since the last reset.
  int ndone_a, ndone_b;
  always @(posedge clk) begin
    if (rst) begin
      ndone_a <= 0;
      ndone_b <= 0;
    end else begin
      if (done_a) ndone_a <= ndone_a + 1;
      if (done_b) ndone_b <= ndone_b + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic pass, input logic flag,
                          input logic [7:0] cnt, input logic [4:0] fea,
                          input logic [15:0] sw);
    chk({tag, "_pass_a"}, 32'(pass_a), 32'(pass));
    chk({tag, "_flag_a"}, 32'(flag_a), 32'(flag));
    chk({tag, "_cnt_a"},  32'(cnt_a),  32'(cnt));
    chk({tag, "_fea_a"},  32'(fea_a),  32'(fea));
    chk({tag, "_sw_a"},   32'(sw_a),   32'(sw));
    chk({tag, "_pass_b"}, 32'(pass_b), 32'(pass));
    chk({tag, "_flag_b"}, 32'(flag_b), 32'(flag));
    chk({tag, "_cnt_b"},  32'(cnt_b),  32'(cnt));
    chk({tag, "_fea_b"},  32'(fea_b),  32'(fea));
    chk({tag, "_sw_b"},   32'(sw_b),   32'(sw));
  endtask

  // Drive one cycle: inputs change on the falling edge, outputs are then
  // observed on the next falling edge.
  task automatic cyc(input logic en, input logic [4:0] a);
    ram_rd_en   = en;
    ram_rd_addr = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, 5'($urandom));
      cyc(1'b1, 5'(i));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 5'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic mem_fill(input bit corrupt);
    for (int i = 0; i < 32; i++) mem[i] = corrupt ? ~8'(i) : 8'(i);
  endtask

  initial begin
    rst         = 1'b1;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    mem_fill(1'b0);
    @(negedge clk);
    do_reset();
    chk_both("reset", 1'b0, 1'b0, 8'd0, 5'd0, 16'd0);
    chk("reset_done_a", 32'(done_a), 32'd0);
    chk("reset_done_b", 32'(done_b), 32'd0);

    // Three continuous sweeps; chk_done lands RD_LAT+1 cycles after address 31.
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 32; a++) begin
        cyc(1'b1, 5'(a));
        if (s > 0 && a == 0) begin
          chk("t1_done_a", 32'(done_a), 32'd1);
          chk("t1_sw_a", 32'(sw_a), 32'(s));
        end
        if (s > 0 && a == 1) begin
          chk("t1_pulse_a", 32'(done_a), 32'd0);
          chk("t1_early_b", 32'(done_b), 32'd0);
        end
        if (s > 0 && a == 2) chk("t1_done_b", 32'(done_b), 32'd1);
      end
    end
    idle(5);
    chk_both("t1", 1'b1, 1'b0, 8'd0, 5'd0, 16'd3);
    chk("t1_ndone_a", 32'(ndone_a), 32'd3);
    chk("t1_ndone_b", 32'(ndone_b), 32'd3);

    // Start mid-sweep at 7: ignored until address 0.
    do_reset();
    issue(7, 31, 1'b0);
    issue(0, 30, 1'b0);
    idle(5);
    chk("t2_sw_a", 32'(sw_a), 32'd0);
    chk("t2_ndone_a", 32'(ndone_a), 32'd0);
    chk("t2_ndone_b", 32'(ndone_b), 32'd0);
    cyc(1'b1, 5'd31);
    cyc(1'b0, 5'd0);
    chk("t2_done_a", 32'(done_a), 32'd1);
    idle(5);
    chk_both("t2", 1'b1, 1'b0, 8'd0, 5'd0, 16'd1);

    // Address 12 corrupted in sweep 2 only.
    do_reset();
    issue(0, 31, 1'b0);
    idle(5);
    chk_both("t3s1", 1'b1, 1'b0, 8'd0, 5'd0, 16'd1);
    mem[12] = 8'hFF;
    issue(0, 31, 1'b0);
    mem[12] = 8'd12;
    idle(5);
    chk_both("t3s2", 1'b0, 1'b1, 8'd1, 5'd12, 16'd2);
    issue(0, 31, 1'b0);
    idle(5);
    chk_both("t3s3", 1'b1, 1'b1, 8'd1, 5'd12, 16'd3);

    // Skip address 20: samples 21..31 mismatch expected 20..30; sweep ends on
    // the following address 0 (expected 31), also an error.
    do_reset();
    issue(0, 19, 1'b0);
    issue(21, 31, 1'b0);
    idle(5);
    chk("t4_sw_a", 32'(sw_a), 32'd0);
    chk("t4_mid_cnt_a", 32'(cnt_a), 32'd11);
    chk("t4_mid_fea_b", 32'(fea_b), 32'd21);
    cyc(1'b1, 5'd0);
    cyc(1'b0, 5'd0);
    chk("t4_done_a", 32'(done_a), 32'd1);
    idle(5);
    chk_both("t4", 1'b0, 1'b1, 8'd12, 5'd21, 16'd1);

    // Gapped reads give the same results; then all words corrupted.
    do_reset();
    issue(0, 31, 1'b1);
    issue(0, 31, 1'b1);
    idle(5);
    chk_both("t5gap", 1'b1, 1'b0, 8'd0, 5'd0, 16'd2);
    mem_fill(1'b1);
    repeat (7) issue(0, 31, 1'b1);
    idle(5);
    chk_both("t5_224", 1'b0, 1'b1, 8'd224, 5'd0, 16'd9);
    repeat (3) issue(0, 31, 1'b0);
    idle(5);
    chk_both("t5_sat", 1'b0, 1'b1, 8'd255, 5'd0, 16'd12);

    // Reset in the middle of a sweep, then resync on the next address 0.
    mem_fill(1'b0);
    do_reset();
    mem[3] = 8'h00;
    issue(0, 31, 1'b0);
    mem[3] = 8'd3;
    idle(5);
    chk_both("t6pre", 1'b0, 1'b1, 8'd1, 5'd3, 16'd1);
    issue(0, 15, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 5'd0);
    rst = 1'b0;
    chk_both("t6rst", 1'b0, 1'b0, 8'd0, 5'd0, 16'd0);
    chk("t6rst_done_a", 32'(done_a), 32'd0);
    issue(16, 31, 1'b0);
    idle(5);
    chk_both("t6drop", 1'b0, 1'b0, 8'd0, 5'd0, 16'd0);
    chk("t6_ndone_a", 32'(ndone_a), 32'd0);
    chk("t6_ndone_b", 32'(ndone_b), 32'd0);
    issue(0, 31, 1'b0);
    idle(5);
    chk_both("t6sync", 1'b1, 1'b0, 8'd0, 5'd0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_rd_chk.md
# ram_rd_chk

Read-side data checker for the dual-port RAM test path. It sits directly downstream of the RAM read port in the `clk_25m` domain. It taps the read enable, address and returned data, re-aligns them across the RAM read latency, and compares each returned word against the write pattern (data equals address). It reports per-sweep pass/fail, a cumulative error count and the first failing address, for LEDs and debug capture.

## Interface
- `ADDR_W`, 5, RAM address width.
- `DATA_W`, 8, RAM data width.
- `DEPTH`, 32, addresses per sweep; must be ≤ 2^ADDR_W.
- `RD_LAT`, 1, RAM read latency in cycles, from `ram_rd_en`/`ram_rd_addr` to valid `ram_rd_data`; range 1..4.
- `clk` input 1: checker clock, same as RAM read clock.
- `rst` input 1: synchronous reset, active-high.
- `ram_rd_en` input 1: read issued this cycle.
- `ram_rd_addr` input ADDR_W: address of the read issued.
- `ram_rd_data` input DATA_W: RAM read data output.
- `chk_done` output 1: one-cycle pulse when a sweep completes.
- `chk_pass` output 1: result of the last completed sweep (1 = no error in that sweep).
- `err_flag` output 1: sticky, set on the first error since reset.
- `err_cnt` output 8: cumulative erroneous samples, saturates at 255.
- `first_err_addr` output ADDR_W: address of the first erroneous sample since reset.
- `sweep_cnt` output 16: completed sweeps, wraps.

## Operation
- **Alignment pipeline.** `ram_rd_en` and `ram_rd_addr` are delayed RD_LAT stages, giving `smp_vld`/`smp_addr`. A sample is `smp_vld` together with the current `ram_rd_data`. Cycles where `smp_vld=0` are ignored entirely.
- **Expected data.** `exp_data = smp_addr` zero-extended or truncated to DATA_W.
- **States: SYNC → CHECK.** SYNC is the reset state.
  - **SYNC.** Samples are discarded until a sample with `smp_addr==0` arrives. That sample is checked as the first of the sweep, and the state moves to CHECK.
  - **CHECK.** `exp_addr` starts at 0 and increments per sample.
  - A sample is erroneous if data ≠ `exp_data` OR `smp_addr` ≠ `exp_addr`. Each erroneous sample counts as one error, even if both conditions fail.
  - When the sample with `exp_addr==DEPTH-1` is checked, the sweep ends:
    - `chk_done` pulses.
    - `chk_pass` loads (sweep error bit == 0, including this last sample).
    - `sweep_cnt` increments.
    - `exp_addr` wraps to 0 and the state stays CHECK. After the first alignment, a later out-of-sequence address is an error, not a resync.
- **Sweep error bit.** Internal; cleared at each sweep end.
- **Error registers.** `err_cnt` increments per error and holds at 255. `first_err_addr` loads only when `err_flag` is 0, in the same cycle `err_flag` sets.

## Timing
- **Reset values.** All outputs are 0; the state is SYNC; the pipeline valids are cleared.
- **Latency.** A read issued at cycle t is compared at t+RD_LAT. The error outputs, `chk_done`, `chk_pass` and `sweep_cnt` update at t+RD_LAT+1 (registered).
- **Throughput.** One sample per cycle; back-to-back and gapped reads are both legal.
- **Simultaneous events.**
  - An error on the last sample of a sweep both increments `err_cnt` and forces `chk_pass=0` in the same update.
  - A first error on the sweep-end sample sets `err_flag`/`first_err_addr` in the same cycle as `chk_done`.
- **Reset mid-sweep.** The partial sweep is discarded with no `chk_done`. Counters and flags clear, and in-flight pipeline samples are dropped.
- **`chk_pass` before the first sweep.** Reads 0; it is only meaningful after the first `chk_done`.

## Structure
- Shared package holds:
  - state encoding (`CHK_SYNC`, `CHK_CHECK`);
  - `ERR_CNT_W=8` and `SWEEP_CNT_W=16`;
  - the helper mapping an address to its expected data.
- One sub-module: `rd_align_pipe`, a parameterised RD_LAT-stage delay for {valid, addr}, with valids reset by `rst`.

## Test plan
- Continuous reads 0..31, data = address, RD_LAT=1 → `chk_done` every 32 samples, `chk_pass=1`, `err_cnt=0`, `sweep_cnt`=1,2,3.
- Reads start at address 7 → samples 7..31 ignored in SYNC; first `chk_done` exactly 32 samples after address 0 is issued; pass.
- Data at address 12 corrupted to 0xFF in sweep 2 only → sweep 2 `chk_pass=0`, `err_flag=1`, `first_err_addr=12`, `err_cnt=1`; sweep 3 `chk_pass=1`.
- Address sequence skips 20 (…19,21…) after alignment → error on sample 21 (expected 20); `first_err_addr=21`; the sweep ends on the sample where `exp_addr` reaches 31 (that sample carries address 0).
- Random gaps in `ram_rd_en`, RD_LAT=3 → results identical to the gap-free run. Then every word corrupted for 10 sweeps → `err_cnt` saturates at 255.
- `rst` asserted at sample 15 of a sweep → next cycle all outputs 0; no `chk_done` for the partial sweep; resync on the next address 0.
